// File: rtl/uart_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_ctl
//  Purpose  : 8N1 UART front end; shows the last good byte on led and
//             optionally echoes it back on tx.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_ctl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       sw,
  output logic       tx,
  output logic [7:0] led
);

  localparam int c_BAUD_DIV = CLK_FREQ / BAUD;
  localparam int c_OVS_DIV  = c_BAUD_DIV / 16;
  localparam int c_BW       = $clog2(c_BAUD_DIV + 1);
  localparam int c_OW       = $clog2(c_OVS_DIV + 1);
  localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(c_BAUD_DIV - 1);
  localparam logic [c_OW-1:0] c_OVS_LAST  = c_OW'(c_OVS_DIV - 1);

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_ERR   = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_WAIT  = 3'd1,
    TX_START = 3'd2,
    TX_DATA  = 3'd3,
    TX_STOP  = 3'd4
  } tx_state_t;

  // ---------------- tick generators ----------------
  logic [c_BW-1:0] r_bcnt;
  logic [c_OW-1:0] r_ocnt;
  logic            w_bit_tick;
  logic            w_ovs_tick;

  assign w_bit_tick = (r_bcnt == c_BAUD_LAST);
  assign w_ovs_tick = (r_ocnt == c_OVS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt <= '0;
      r_ocnt <= '0;
    end else begin
      r_bcnt <= w_bit_tick ? '0 : r_bcnt + c_BW'(1);
      r_ocnt <= w_ovs_tick ? '0 : r_ocnt + c_OW'(1);
    end
  end

  // ---------------- rx synchronizer ----------------
  // Reset to the idle level so reset release never looks like a start edge.
  logic r_rx_meta;
  logic r_rx_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t  r_rx_state, w_rx_state_nxt;
  logic [3:0] r_rx_cnt,   w_rx_cnt_nxt;
  logic [2:0] r_rx_n,     w_rx_n_nxt;
  logic [7:0] r_shreg,    w_shreg_nxt;
  logic [7:0] r_led,      w_led_nxt;
  logic       r_rx_done,  w_rx_done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_n     <= '0;
      r_shreg    <= '0;
      r_led      <= '0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_n     <= w_rx_n_nxt;
      r_shreg    <= w_shreg_nxt;
      r_led      <= w_led_nxt;
      r_rx_done  <= w_rx_done_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_n_nxt     = r_rx_n;
    w_shreg_nxt    = r_shreg;
    w_led_nxt      = r_led;
    w_rx_done_nxt  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        // Mid start bit: a high line here means the edge was a glitch.
        if (w_ovs_tick) begin
          if (r_rx_cnt == 4'd7) begin
            w_rx_cnt_nxt   = '0;
            w_rx_n_nxt     = '0;
            w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (w_ovs_tick) begin
          w_rx_cnt_nxt = r_rx_cnt + 4'd1;
          if (r_rx_cnt == 4'd15) begin
            w_shreg_nxt = {r_rx_sync, r_shreg[7:1]};
            if (r_rx_n == 3'd7) begin
              w_rx_state_nxt = RX_STOP;
            end else begin
              w_rx_n_nxt = r_rx_n + 3'd1;
            end
          end
        end
      end
      RX_STOP: begin
        if (w_ovs_tick) begin
          w_rx_cnt_nxt = r_rx_cnt + 4'd1;
          if (r_rx_cnt == 4'd15) begin
            if (r_rx_sync) begin
              w_led_nxt      = r_shreg;
              w_rx_done_nxt  = 1'b1;
              w_rx_state_nxt = RX_IDLE;
            end else begin
              w_rx_state_nxt = RX_ERR;
            end
          end
        end
      end
      RX_ERR: begin
        if (r_rx_sync) begin
          w_rx_state_nxt = RX_IDLE;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  assign led = r_led;

  // ---------------- transmitter ----------------
  tx_state_t  r_tx_state, w_tx_state_nxt;
  logic [7:0] r_tx_byte,  w_tx_byte_nxt;
  logic [2:0] r_tx_n,     w_tx_n_nxt;
  logic       r_tx,       w_tx_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_byte  <= '0;
      r_tx_n     <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_tx_n     <= w_tx_n_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  // r_led already holds the new byte in the cycle r_rx_done is high.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_byte_nxt  = r_tx_byte;
    w_tx_n_nxt     = r_tx_n;
    w_tx_nxt       = r_tx;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_nxt = 1'b1;
        if (r_rx_done && sw) begin
          w_tx_byte_nxt  = r_led;
          w_tx_state_nxt = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (w_bit_tick) begin
          w_tx_nxt       = 1'b0;
          w_tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (w_bit_tick) begin
          w_tx_nxt       = r_tx_byte[0];
          w_tx_byte_nxt  = {1'b1, r_tx_byte[7:1]};
          w_tx_n_nxt     = '0;
          w_tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        if (w_bit_tick) begin
          if (r_tx_n == 3'd7) begin
            w_tx_nxt       = 1'b1;
            w_tx_state_nxt = TX_STOP;
          end else begin
            w_tx_nxt      = r_tx_byte[0];
            w_tx_byte_nxt = {1'b1, r_tx_byte[7:1]};
            w_tx_n_nxt    = r_tx_n + 3'd1;
          end
        end
      end
      TX_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_tick) begin
          w_tx_state_nxt = TX_IDLE;
        end
      end
      default: begin
        w_tx_nxt       = 1'b1;
        w_tx_state_nxt = TX_IDLE;
      end
    endcase
  end

  assign tx = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_ctl
//  Purpose  : Self-checking bench for uart_ctl (scaled-down baud rate).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_ctl;

  localparam int CLK_FREQ = 640_000;
  localparam int BAUD     = 10_000;
  localparam int BIT      = CLK_FREQ / BAUD;   // 64 clk per bit
  localparam int OVS      = BIT / 16;          // 4 clk per oversample tick

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       sw  = 1'b0;
  logic       tx;
  logic [7:0] led;

  always #5 clk = ~clk;

  uart_ctl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .sw(sw), .tx(tx), .led(led)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  logic [7:0] rx_q[$];    // bytes decoded from tx
  logic [7:0] exp_q[$];   // bytes the model expects to be echoed

  // Posedges since reset release; bit ticks land on multiples of BIT.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // tx line decoder: samples each bit in its middle.
  initial begin : g_mon
    logic [7:0] b;
    logic prev;
    prev = 1'b1;
    b = '0;
    forever begin
      @(negedge clk);
      if (!rst && prev && !tx) begin
        repeat (BIT/2) @(negedge clk);
        check("tx_start_bit", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        check("tx_stop_bit", tx, 1'b1);
        rx_q.push_back(b);
      end
      prev = tx;
    end
  end

  // Every tx transition must sit on the free-running bit-tick grid.
  initial begin : g_grid
    logic last;
    last = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && tx !== last) check("tx_edge_on_bit_grid", cyc % BIT, 0);
      last = tx;
    end
  end

  task automatic drive(input logic v, input int cycles);
    rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_body(input logic [7:0] d);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(d[i], BIT);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       sw;
    logic [7:0] exp_led;
    logic       exp_echo;
  } vec_t;

  initial begin : g_main
    vec_t       vecs[4];
    logic [7:0] prev_led;
    logic [7:0] model_led;
    logic [7:0] d;
    logic       good;
    logic       s;

    vecs[0] = '{8'hAE, 1'b1, 1'b0, 8'hAE, 1'b0};
    vecs[1] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1};
    vecs[2] = '{8'hAE, 1'b0, 1'b1, 8'h55, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1};

    // Reset and idle line
    repeat (10) @(negedge clk);
    check("reset_led", led, 8'h00);
    check("reset_tx", tx, 1'b1);
    rst = 1'b0;
    drive(1'b1, 5*BIT);
    check("idle_led", led, 8'h00);
    check("idle_tx", tx, 1'b1);
    check("idle_no_echo", rx_q.size(), 0);

    // Table of directed frames
    prev_led = 8'h00;
    for (int i = 0; i < 4; i++) begin
      sw = vecs[i].sw;
      rx_q.delete();
      send_body(vecs[i].data);
      drive(vecs[i].stop, 4*OVS);
      check("led_before_stop_sample", led, prev_led);
      drive(vecs[i].stop, 12*OVS);
      check("vec_led", led, vecs[i].exp_led);
      drive(1'b1, 12*BIT);
      check("vec_echo_count", rx_q.size(), {31'd0, vecs[i].exp_echo});
      if (rx_q.size() != 0) check("vec_echo_byte", rx_q[0], vecs[i].data);
      check("vec_tx_idle", tx, 1'b1);
      prev_led = vecs[i].exp_led;
    end

    // Short low pulse is a glitch; receiver must still take the next frame
    sw = 1'b0;
    rx_q.delete();
    drive(1'b0, 4*OVS);
    drive(1'b1, 2*BIT);
    check("glitch_led", led, 8'h3C);
    send_body(8'hC3);
    drive(1'b1, BIT);
    check("after_glitch_led", led, 8'hC3);
    drive(1'b1, 2*BIT);

    // Break: line held low
    drive(1'b0, 20*BIT);
    check("break_led", led, 8'hC3);
    drive(1'b1, 2*BIT);
    send_body(8'h96);
    drive(1'b1, BIT);
    check("after_break_led", led, 8'h96);
    drive(1'b1, 12*BIT);
    check("break_no_echo", rx_q.size(), 0);

    // Second byte arrives while the first echo is still on the line
    sw = 1'b1;
    rx_q.delete();
    send_body(8'h5A);
    drive(1'b1, 11*OVS);
    send_body(8'hA5);
    drive(1'b1, BIT);
    check("busy_led", led, 8'hA5);
    drive(1'b1, 14*BIT);
    check("busy_echo_count", rx_q.size(), 1);
    if (rx_q.size() != 0) check("busy_echo_byte", rx_q[0], 8'h5A);

    // Randomized frames against the model
    model_led = 8'hA5;
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      s    = 1'($urandom_range(0, 1));
      sw   = s;
      send_body(d);
      drive(good, BIT);
      if (good) begin
        model_led = d;
        if (s) exp_q.push_back(d);
      end
      check("rand_led", led, model_led);
      if ($urandom_range(0, 1) != 0) sw = ~sw;
      drive(1'b1, $urandom_range(2, 4) * BIT);
    end
    drive(1'b1, 12*BIT);
    check("rand_echo_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check("rand_echo_byte", rx_q[i], exp_q[i]);

    // Reset in the middle of a received frame
    sw = 1'b0;
    rx_q.delete();
    d = 8'h81;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(d[i], BIT);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset_led", led, 8'h00);
    check("midreset_tx", tx, 1'b1);
    rx  = 1'b1;
    rst = 1'b0;
    drive(1'b1, 2*BIT);
    check("post_reset_led", led, 8'h00);
    send_body(8'h81);
    drive(1'b1, BIT);
    check("post_reset_frame_led", led, 8'h81);
    drive(1'b1, 2*BIT);
    check("post_reset_tx", tx, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : g_watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
